// File: rtl/seg7_count_monitor.sv
// Receive-side checker for a 3-bit counter and its 7-segment display: decodes the pattern,
// cross-checks it against the count, tracks +1 mod 8 sequencing. Option: SEG7_ACTIVE_HIGH_EN.
module seg7_count_monitor #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [2:0]       iQ,
  input  logic [6:0]       iDisplay,
  output logic [2:0]       oDigit,
  output logic             oValid,
  output logic             oSegErr,
  output logic             oSeqErr,
  output logic             oLocked,
  output logic [ERR_W-1:0] oErrCnt
);

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_t           state_q;
  logic [2:0]       s_cnt_q, p_cnt_q;
  logic [6:0]       s_seg_q, p_seg_q;
  logic             s_vld_q, primed_q;
  logic [3:0]       run_q;
  logic [ERR_W-1:0] err_q;
  logic [2:0]       digit_q;
  logic             valid_q, seg_err_q, seq_err_q;

  logic [6:0] seg_lo;
  logic [2:0] dec_d;
  logic       legal_d;
  logic [2:0] exp_cnt_d;
  logic [3:0] run_d;
  logic       step_d, seg_bad_d, seq_bad_d, good_d;

  // Normalise to active-low so one decode table serves both polarities.
`ifdef SEG7_ACTIVE_HIGH_EN
  assign seg_lo = ~s_seg_q;
`else
  assign seg_lo = s_seg_q;
`endif

  always_comb begin
    dec_d   = 3'd0;
    legal_d = 1'b1;
    case (seg_lo)
      7'h40:   dec_d = 3'd0;
      7'h79:   dec_d = 3'd1;
      7'h24:   dec_d = 3'd2;
      7'h30:   dec_d = 3'd3;
      7'h19:   dec_d = 3'd4;
      7'h12:   dec_d = 3'd5;
      7'h02:   dec_d = 3'd6;
      7'h78:   dec_d = 3'd7;
      default: legal_d = 1'b0;
    endcase
  end

  // A step is any change of the captured {count, pattern}; P must hold a real sample first.
  assign step_d    = primed_q && ({s_cnt_q, s_seg_q} != {p_cnt_q, p_seg_q});
  assign exp_cnt_d = p_cnt_q + 3'd1;
  assign seg_bad_d = !legal_d || (dec_d != s_cnt_q);
  assign seq_bad_d = (s_cnt_q != exp_cnt_d);
  assign good_d    = !seg_bad_d && !seq_bad_d;
  assign run_d     = run_q + 4'd1;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      s_cnt_q   <= 3'd0;
      s_seg_q   <= 7'd0;
      p_cnt_q   <= 3'd0;
      p_seg_q   <= 7'd0;
      s_vld_q   <= 1'b0;
      primed_q  <= 1'b0;
      run_q     <= 4'd0;
      err_q     <= '0;
      digit_q   <= 3'd0;
      valid_q   <= 1'b0;
      seg_err_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      s_cnt_q   <= iQ;
      s_seg_q   <= iDisplay;
      p_cnt_q   <= s_cnt_q;
      p_seg_q   <= s_seg_q;
      s_vld_q   <= 1'b1;
      primed_q  <= s_vld_q;
      valid_q   <= step_d && legal_d;
      seg_err_q <= step_d && seg_bad_d;
      seq_err_q <= step_d && seq_bad_d;
      if (step_d) begin
        digit_q <= legal_d ? dec_d : 3'd0;
        case (state_q)
          HUNT: begin
            if (!good_d) begin
              run_q <= 4'd0;
            end else if (run_d == LOCK_V) begin
              run_q   <= 4'd0;
              state_q <= TRACK;
            end else begin
              run_q <= run_d;
            end
          end
          TRACK: begin
            // One increment per bad step, even when both checks fail together.
            if (!good_d) begin
              if (err_q != ERR_MAX) err_q <= err_q + ERR_ONE;
              run_q   <= 4'd0;
              state_q <= HUNT;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign oDigit  = digit_q;
  assign oValid  = valid_q;
  assign oSegErr = seg_err_q;
  assign oSeqErr = seq_err_q;
  assign oLocked = (state_q == TRACK);
  assign oErrCnt = err_q;

endmodule

// File: tb/tb_seg7_count_monitor.sv
// Directed bench for seg7_count_monitor: main instance (ERR_W=8) and a saturation
// instance (ERR_W=2) share the same stimulus.
module tb_seg7_count_monitor;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] iQ = 3'd0;
  logic [6:0] iDisplay = 7'h00;

  logic [2:0] m_digit, s_digit;
  logic       m_valid, m_seg, m_seq, m_locked;
  logic       s_valid, s_seg, s_seq, s_locked;
  logic [7:0] m_err;
  logic [1:0] s_err;

  int n_vec  = 0;
  int n_miss = 0;

  logic [6:0] seg_lut [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  seg7_count_monitor #(.LOCK_CNT(4), .ERR_W(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .iQ(iQ), .iDisplay(iDisplay),
    .oDigit(m_digit), .oValid(m_valid), .oSegErr(m_seg), .oSeqErr(m_seq),
    .oLocked(m_locked), .oErrCnt(m_err)
  );

  seg7_count_monitor #(.LOCK_CNT(4), .ERR_W(2)) dut_sat (
    .CLK(CLK), .rst_n(rst_n), .iQ(iQ), .iDisplay(iDisplay),
    .oDigit(s_digit), .oValid(s_valid), .oSegErr(s_seg), .oSeqErr(s_seq),
    .oLocked(s_locked), .oErrCnt(s_err)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] drv(input logic [6:0] lo);
`ifdef SEG7_ACTIVE_HIGH_EN
    return ~lo;
`else
    return lo;
`endif
  endfunction

  task automatic check_zero(input string tag);
    check_vec({tag, "_digit"}, m_digit, 0);
    check_vec({tag, "_valid"}, m_valid, 0);
    check_vec({tag, "_seg"}, m_seg, 0);
    check_vec({tag, "_seq"}, m_seq, 0);
    check_vec({tag, "_locked"}, m_locked, 0);
    check_vec({tag, "_err"}, m_err, 0);
    check_vec({tag, "_err_w2"}, s_err, 0);
  endtask

  // Driver: present one value, check the step pulse 2 edges later, then check it ends.
  task automatic apply_step(input logic [2:0] q, input logic [6:0] disp_lo,
                            input logic e_valid, input logic e_seg, input logic e_seq,
                            input logic [2:0] e_digit, input logic e_locked, input int e_err);
    @(negedge CLK);
    iQ       = q;
    iDisplay = drv(disp_lo);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_vec("valid", m_valid, e_valid);
    check_vec("seg_err", m_seg, e_seg);
    check_vec("seq_err", m_seq, e_seq);
    check_vec("digit", m_digit, e_digit);
    check_vec("locked", m_locked, e_locked);
    check_vec("err_cnt", m_err, e_err);
    check_vec("err_cnt_w2", s_err, (e_err > 3) ? 3 : e_err);
    check_vec("locked_w2", s_locked, e_locked);
    @(posedge CLK);
    #1;
    check_vec("pulse_end", {m_valid, m_seg, m_seq}, 3'b000);
    check_vec("digit_hold", m_digit, e_digit);
    check_vec("locked_hold", m_locked, e_locked);
    @(posedge CLK);
  endtask

  task automatic good_step(input logic [2:0] q, input logic e_locked, input int e_err);
    apply_step(q, seg_lut[q], 1'b1, 1'b0, 1'b0, q, e_locked, e_err);
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      check_vec(tag, {m_valid, m_seg, m_seq}, 3'b000);
    end
  endtask

  initial begin
    iQ       = 3'd0;
    iDisplay = drv(seg_lut[0]);
    #12;
    check_zero("reset");
    #8;
    rst_n = 1'b1;
    quiet_cycles("prime", 3);

    // Clean count with wrap
    good_step(3'd1, 1'b0, 0);
    good_step(3'd2, 1'b0, 0);
    good_step(3'd3, 1'b0, 0);
    good_step(3'd4, 1'b1, 0);
    good_step(3'd5, 1'b1, 0);
    good_step(3'd6, 1'b1, 0);
    good_step(3'd7, 1'b1, 0);
    good_step(3'd0, 1'b1, 0);
    good_step(3'd1, 1'b1, 0);
    good_step(3'd2, 1'b1, 0);

    // Segment corruption in TRACK, then relock
    apply_step(3'd3, 7'h24, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1);
    good_step(3'd4, 1'b0, 1);
    good_step(3'd5, 1'b0, 1);
    good_step(3'd6, 1'b0, 1);
    good_step(3'd7, 1'b1, 1);

    // Skipped count 5 -> 7
    for (int v = 0; v <= 5; v++) good_step(3'(v), 1'b1, 1);
    apply_step(3'd7, seg_lut[7], 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 2);
    good_step(3'd0, 1'b0, 2);
    good_step(3'd1, 1'b0, 2);
    good_step(3'd2, 1'b0, 2);
    good_step(3'd3, 1'b1, 2);

    // Double fault 1 -> 4 with blank pattern
    good_step(3'd4, 1'b1, 2);
    good_step(3'd5, 1'b1, 2);
    good_step(3'd6, 1'b1, 2);
    good_step(3'd7, 1'b1, 2);
    good_step(3'd0, 1'b1, 2);
    good_step(3'd1, 1'b1, 2);
    apply_step(3'd4, 7'h7F, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 3);

    // Two more lock-then-error rounds: ERR_W=2 instance holds at 3
    good_step(3'd5, 1'b0, 3);
    good_step(3'd6, 1'b0, 3);
    good_step(3'd7, 1'b0, 3);
    good_step(3'd0, 1'b1, 3);
    apply_step(3'd2, seg_lut[2], 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 4);
    good_step(3'd3, 1'b0, 4);
    good_step(3'd4, 1'b0, 4);
    good_step(3'd5, 1'b0, 4);
    good_step(3'd6, 1'b1, 4);
    apply_step(3'd0, seg_lut[0], 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 5);
    good_step(3'd1, 1'b0, 5);
    good_step(3'd2, 1'b0, 5);
    good_step(3'd3, 1'b0, 5);
    good_step(3'd4, 1'b1, 5);

    // Async reset between edges while locked
    @(posedge CLK);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge CLK);
    rst_n = 1'b1;
    quiet_cycles("post_rst", 3);
    good_step(3'd5, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seg7_count_monitor.md
# seg7_count_monitor

Receive-side checker for the 3-bit counter and 7-segment display pair driven by the counter block. It decodes the segment pattern back into a digit and cross-checks it against the binary count. It verifies that successive values advance by +1 modulo 8, and keeps a saturating error count. It sits beside the counter, either on-chip as a self-test or in simulation, and takes the counter's `oQ`/`oDisplay` directly.

## Interface
Parameters:
- `LOCK_CNT`, default 4: consecutive good steps needed to reach TRACK (legal range 1..15).
- `ERR_W`, default 8: width of the error counter.

Ports (clock and reset first):
- `CLK`  in  1  system clock; rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `iQ`  in  3  binary count from the counter.
- `iDisplay`  in  7  segment pattern; bit order {g,f,e,d,c,b,a}; active-low by default.
- `oDigit`  out  3  digit decoded from the last step.
- `oValid`  out  1  one-cycle pulse: a step was evaluated and the pattern was legal.
- `oSegErr`  out  1  one-cycle pulse: the pattern is illegal, or it decodes to a value other than `iQ`.
- `oSeqErr`  out  1  one-cycle pulse: `iQ` is not the previous `iQ` + 1 mod 8.
- `oLocked`  out  1  high while the FSM is in TRACK.
- `oErrCnt`  out  ERR_W  count of erroneous steps seen in TRACK; saturates.

## Operation
- Decode table, active-low, {g..a}:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30
  - 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78
  - Any other pattern is illegal. An illegal pattern sets `oDigit` to 0 and asserts `oSegErr`.
- The inputs are registered every cycle into sample register S. The previous contents of S are kept in P.
- A step is a cycle in which S ≠ P, comparing {`iQ`,`iDisplay`}. Stable inputs generate no events, so a slow or divided counter is handled.
- After reset, the first captured sample only primes P. A `primed` flag gates evaluation, so the first sample raises no error.
- Step evaluation:
  - segment check: decode(S.disp) is legal and equals S.q.
  - sequence check: S.q == (P.q + 1) mod 8; the 3-bit wrap 7→0 is legal.
- FSM:
  - HUNT (reset state):
    - good step: run count += 1.
    - bad step: run count = 0.
    - run count reaching `LOCK_CNT`: go to TRACK.
    - Errors are flagged in HUNT but not counted.
  - TRACK:
    - good step: stay.
    - bad step: `oErrCnt` += 1, saturating at 2^ERR_W−1; run count = 0; go to HUNT.
- When both checks fail on the same step, both flags pulse and `oErrCnt` increments by 1 only.
- `oDigit` holds its value between steps.

## Timing
- Inputs present before edge N are captured in S at edge N.
- Step evaluation is combinational from S/P. All outputs are registered at edge N+1, giving 1-cycle latency from capture.
- `oValid`, `oSegErr` and `oSeqErr` are high for exactly one cycle per step.
- `oLocked` rises at the same edge as the `oValid` of the `LOCK_CNT`-th good step. It falls at the same edge as the error pulse.
- Reset values: `oDigit` = 0, `oValid` = 0, `oSegErr` = 0, `oSeqErr` = 0, `oLocked` = 0, `oErrCnt` = 0. S, P, run count and `primed` are also cleared, and the FSM returns to HUNT.
- Reset mid-operation takes effect immediately, with no clock needed. Any pending pulse is dropped.
- After reset release, the first step is evaluated no earlier than the second captured sample.

## Configuration
- `SEG7_ACTIVE_HIGH_EN`:
  - When defined, `iDisplay` is bitwise inverted before decoding, so the table applies to active-high segments (0 = 7'h3F, 7 = 7'h07, and so on).
  - When undefined, segments are active-low exactly as in the table.
  - Nothing else changes, including timing.

## Test plan
- Clean count: drive the counter sequence 0..7..0 with correct patterns, one value every 4 cycles, after `rst_n` releases at 20 ns. Required: `oValid` pulses on every step, with no error pulses; `oLocked` rises on the 4th good step; `oErrCnt` = 0 across the 7→0 wrap.
- Segment corruption in TRACK: present `iQ`=3 with `iDisplay`=7'h24. Required: one `oSegErr` pulse with `oSeqErr`=0, `oDigit`=2, `oErrCnt`=1, and `oLocked` falls. It relocks after 4 good steps.
- Skipped count: in TRACK, step from 5 to 7 with correct patterns. Required: `oSeqErr` pulse, `oErrCnt` increments by 1, return to HUNT.
- Double fault: in TRACK, step from 1 to `iQ`=4 with `iDisplay`=7'h7F. Required: `oSegErr` and `oSeqErr` in the same cycle, `oErrCnt` +1 only, `oDigit`=0.
- Saturation: with ERR_W=2, force 5 lock-then-error cycles. Required: `oErrCnt` stops at 3.
- Async reset: drop `rst_n` mid-TRACK between clock edges. Required: all outputs are 0 before the next edge; the first post-reset sample raises no error.
